pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//   Parametrised elastic pipeline-stage register: the generalised successor of the fixed
//   IF/ID register. It replaces freeze with a valid/ready handshake, adds a 2-entry skid
//   buffer for full throughput under back-pressure, and adds synchronous flush (squash)
//   plus saturating stall/flush event counters. Sits between any two pipeline stages.
// PARAMETERS
//   PC_W           32  width of PC field
//   DATA_W         32  width of payload field (instruction or stage bundle)
//   CNT_W          16  width of each event counter
//   CLEAR_ON_FLUSH 1   1: payload regs zeroed on flush/empty; 0: payload held, only valids drop
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       reset, asynchronous, active-high
//   flush      in   1       synchronous squash of all held entries
//   cnt_clr    in   1       synchronous clear of both counters
//   in_valid   in   1       upstream offers entry
//   in_ready   out  1       stage can accept; transfer = in_valid & in_ready
//   in_pc      in   PC_W    upstream PC
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       main entry valid
//   out_ready  in   1       downstream accepts; transfer = out_valid & out_ready
//   out_pc     out  PC_W    PC of main entry
//   out_data   out  DATA_W  payload of main entry
//   stall_cnt  out  CNT_W   cycles with out_valid & !out_ready
//   flush_cnt  out  CNT_W   flushes that squashed >=1 valid entry
// BEHAVIOUR
// - Storage: main reg (drives out_*) + skid reg. State EMPTY / ONE / TWO = occupancy.
// - in_ready = (state != TWO), decoded from registered state only; no comb path from out_ready.
// - out_valid = (state != EMPTY); out_pc/out_data come directly from the main reg.
// - Reset (async): state EMPTY, in_ready=1, out_valid=0, out_pc=0, out_data=0, skid=0,
//   both counters 0.
// - Transitions (no flush):
//     EMPTY: in xfer -> ONE, main<=in.
//     ONE: in xfer & out_ready -> ONE, main<=in.
//          in xfer & !out_ready -> TWO, skid<=in.
//          no in xfer & out_ready -> EMPTY.
//          else hold.
//     TWO: out_ready -> ONE, main<=skid; no input accepted (in_ready=0). Else hold.
// - Latency 1 cycle from input transfer to out_valid when EMPTY; throughput 1 entry/cycle;
//   strict FIFO order; no entry is dropped or duplicated.
// - flush: overrides all transitions; next state EMPTY.
//   Input offered in the flush cycle is discarded, even when in_ready=1.
//   An output transfer in the flush cycle completes normally, because downstream sees
//   out_valid that cycle.
//   With CLEAR_ON_FLUSH=1, main and skid are zeroed. A flush while EMPTY is legal and
//   has no other effect.
// - With CLEAR_ON_FLUSH=1, the main reg is also zeroed on a ONE->EMPTY drain, so out_* = 0
//   whenever out_valid=0.
// - stall_cnt: +1 each cycle out_valid & !out_ready, including the flush cycle; saturates
//   at all-ones.
// - flush_cnt: +1 when flush & state != EMPTY; saturates at all-ones.
// - cnt_clr: has priority over increment; counters read 0 next cycle.
// - rst asserted mid-transfer: all state is lost immediately; the stage is EMPTY and
//   in_ready=1 on the first edge after deassertion.
// TESTING
// 1. Stream 0x100,0x104,0x108 with in_valid=1, out_ready=1 -> out_pc 0x100,0x104,0x108 on
//    consecutive cycles, 1-cycle latency, in_ready stays 1.
// 2. Stream 4 entries, out_ready=0 for 3 cycles from cycle 2 -> in_ready=0 after 2 held
//    entries; all 4 emerge in order after release; stall_cnt=3.
// 3. State TWO (0x200 main, 0x204 skid), flush=1 with in_valid=1 (0x208) -> next cycle
//    out_valid=0, out_pc=0, in_ready=1, flush_cnt=1; 0x208 never appears.
// 4. Flush while EMPTY -> flush_cnt unchanged, no out_valid pulse.
// 5. CNT_W=4, out_ready=0 for 20 cycles with a valid entry -> stall_cnt saturates at 15;
//    cnt_clr -> 0 next cycle.
// 6. Assert rst asynchronously in state TWO mid-cycle -> out_valid=0, out_pc=0 immediately;
//    after release, entry 0x300 traverses with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, synchronous flush,
// and saturating stall/flush event counters.
module pipe_stage_skid_reg #(
  parameter int unsigned PC_W           = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 16,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [PC_W-1:0]   main_pc_r, main_pc_s, skid_pc_r, skid_pc_s;
  logic [DATA_W-1:0] main_data_r, main_data_s, skid_data_r, skid_data_s;
  logic              in_ready_r, out_valid_r;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              in_xfer_s, stall_evt_s, flush_evt_s;

  assign in_xfer_s   = in_valid & in_ready_r;
  assign stall_evt_s = out_valid_r & ~out_ready;
  assign flush_evt_s = flush & (state_r != EMPTY);

  // Next-state and payload steering; flush overrides every transition.
  always_comb begin
    state_s     = state_r;
    main_pc_s   = main_pc_r;
    main_data_s = main_data_r;
    skid_pc_s   = skid_pc_r;
    skid_data_s = skid_data_r;
    if (flush) begin
      state_s = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_pc_s   = {PC_W{1'b0}};
        main_data_s = {DATA_W{1'b0}};
        skid_pc_s   = {PC_W{1'b0}};
        skid_data_s = {DATA_W{1'b0}};
      end else begin
        main_pc_s = main_pc_r;
      end
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            state_s     = ONE;
            main_pc_s   = in_pc;
            main_data_s = in_data;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (in_xfer_s && out_ready) begin
            main_pc_s   = in_pc;
            main_data_s = in_data;
          end else if (in_xfer_s) begin
            state_s     = TWO;
            skid_pc_s   = in_pc;
            skid_data_s = in_data;
          end else if (out_ready) begin
            state_s = EMPTY;
            // Keep out_* at zero whenever out_valid is low.
            if (CLEAR_ON_FLUSH) begin
              main_pc_s   = {PC_W{1'b0}};
              main_data_s = {DATA_W{1'b0}};
            end else begin
              main_pc_s = main_pc_r;
            end
          end else begin
            state_s = ONE;
          end
        end
        TWO: begin
          if (out_ready) begin
            state_s     = ONE;
            main_pc_s   = skid_pc_r;
            main_data_s = skid_data_r;
          end else begin
            state_s = TWO;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end
  end

  // State, payload and handshake flags; ready/valid are registered decodes of next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_pc_r   <= {PC_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
      skid_pc_r   <= {PC_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      main_pc_r   <= main_pc_s;
      main_data_r <= main_data_s;
      skid_pc_r   <= skid_pc_s;
      skid_data_r <= skid_data_s;
      in_ready_r  <= (state_s != TWO);
      out_valid_r <= (state_s != EMPTY);
    end
  end

  // Saturating event counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_pc    = main_pc_r;
  assign out_data  = main_data_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed self-checking bench for pipe_stage_skid_reg (CNT_W=4 to reach saturation).
module tb_pipe_stage_skid_reg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush, cnt_clr, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid_reg #(
    .PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .CLEAR_ON_FLUSH(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_data   = ~pc;
    out_ready = rdy;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc);
    check({tag, "_valid"}, {63'd0, out_valid}, {63'd0, v});
    check({tag, "_pc"}, {32'd0, out_pc}, {32'd0, pc});
    check({tag, "_data"}, {32'd0, out_data}, v ? {32'd0, ~pc} : 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    offer(1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("reset", 1'b0, 32'h0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_stall", {60'd0, stall_cnt}, 64'd0);
    check("reset_flush", {60'd0, flush_cnt}, 64'd0);

    // 1: full-rate stream
    offer(1'b1, 32'h100, 1'b1); tick(); expect_out("s1_a", 1'b1, 32'h100);
    check("s1_rdy_a", {63'd0, in_ready}, 64'd1);
    offer(1'b1, 32'h104, 1'b1); tick(); expect_out("s1_b", 1'b1, 32'h104);
    offer(1'b1, 32'h108, 1'b1); tick(); expect_out("s1_c", 1'b1, 32'h108);
    check("s1_rdy_c", {63'd0, in_ready}, 64'd1);
    offer(1'b0, 32'h0, 1'b1); tick(); expect_out("s1_drain", 1'b0, 32'h0);

    // 2: back-pressure fills the skid, then releases in order
    offer(1'b1, 32'h110, 1'b1); tick(); expect_out("s2_a0", 1'b1, 32'h110);
    offer(1'b1, 32'h114, 1'b0); tick(); expect_out("s2_hold1", 1'b1, 32'h110);
    check("s2_rdy_two", {63'd0, in_ready}, 64'd0);
    offer(1'b1, 32'h118, 1'b0); tick(); expect_out("s2_hold2", 1'b1, 32'h110);
    offer(1'b1, 32'h118, 1'b0); tick(); expect_out("s2_hold3", 1'b1, 32'h110);
    check("s2_rdy_hold", {63'd0, in_ready}, 64'd0);
    offer(1'b1, 32'h118, 1'b1); tick(); expect_out("s2_a1", 1'b1, 32'h114);
    check("s2_rdy_rel", {63'd0, in_ready}, 64'd1);
    offer(1'b1, 32'h118, 1'b1); tick(); expect_out("s2_a2", 1'b1, 32'h118);
    offer(1'b1, 32'h11C, 1'b1); tick(); expect_out("s2_a3", 1'b1, 32'h11C);
    offer(1'b0, 32'h0, 1'b1); tick(); expect_out("s2_drain", 1'b0, 32'h0);
    check("s2_stall", {60'd0, stall_cnt}, 64'd3);

    // 3: flush from TWO discards the input offered that cycle
    offer(1'b1, 32'h200, 1'b0); tick();
    offer(1'b1, 32'h204, 1'b0); tick(); expect_out("s3_two", 1'b1, 32'h200);
    check("s3_rdy_two", {63'd0, in_ready}, 64'd0);
    offer(1'b1, 32'h208, 1'b0); flush = 1'b1; tick(); flush = 1'b0;
    expect_out("s3_flushed", 1'b0, 32'h0);
    check("s3_rdy", {63'd0, in_ready}, 64'd1);
    check("s3_flush_cnt", {60'd0, flush_cnt}, 64'd1);
    check("s3_stall", {60'd0, stall_cnt}, 64'd5);
    offer(1'b0, 32'h0, 1'b1); tick(); expect_out("s3_after", 1'b0, 32'h0);

    // 4: flush while empty
    flush = 1'b1; tick(); flush = 1'b0;
    expect_out("s4_empty", 1'b0, 32'h0);
    check("s4_flush_cnt", {60'd0, flush_cnt}, 64'd1);

    // 5: stall counter saturation and clear
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("s5_clr0", {60'd0, stall_cnt}, 64'd0);
    check("s5_fclr0", {60'd0, flush_cnt}, 64'd0);
    offer(1'b1, 32'h400, 1'b0); tick();
    offer(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("s5_sat", {60'd0, stall_cnt}, 64'd15);
    expect_out("s5_held", 1'b1, 32'h400);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("s5_clr", {60'd0, stall_cnt}, 64'd0);

    // 6: async reset in TWO, then a fresh entry
    offer(1'b1, 32'h404, 1'b0); tick();
    check("s6_rdy_two", {63'd0, in_ready}, 64'd0);
    offer(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_out("s6_async", 1'b0, 32'h0);
    check("s6_rdy", {63'd0, in_ready}, 64'd1);
    check("s6_stall", {60'd0, stall_cnt}, 64'd0);
    #2 rst = 1'b0;
    offer(1'b1, 32'h300, 1'b1); tick(); expect_out("s6_new", 1'b1, 32'h300);
    offer(1'b0, 32'h0, 1'b1); tick(); expect_out("s6_drain", 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
